// File: rtl/rom_adapter_pkg.sv
// Shared types and helpers for the boot-ROM request adapter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rom_adapter_pkg;

    // One buffered response: error flag plus read data (data is 0 on error).
    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rom_resp_t;

    localparam int unsigned ROM_RESP_W = $bits(rom_resp_t);

    // Size of the ROM window in bytes: one 32-bit word per ROM index.
    // Returned in 33 bits so a full 4 GiB window does not wrap to zero.
    function automatic logic [32:0] rom_window_bytes(input int unsigned addr_width);
        return 33'd4 << addr_width;
    endfunction

    // Error response: flagged, with data forced to zero.
    function automatic rom_resp_t rom_err_resp();
        rom_resp_t r;
        r.err  = 1'b1;
        r.data = 32'h0;
        return r;
    endfunction

    // Good response carrying one ROM word.
    function automatic rom_resp_t rom_ok_resp(input logic [31:0] data);
        rom_resp_t r;
        r.err  = 1'b0;
        r.data = data;
        return r;
    endfunction

endpackage

// File: rtl/rom_resp_fifo.sv
// Synchronous FIFO of ROM responses, any depth >= 1 (pointers wrap at Depth).
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; callers must not push while full (credit-managed).
module rom_resp_fifo
    import rom_adapter_pkg::*;
#(
    parameter int unsigned Depth = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  rom_resp_t                    push_dat_i,
    input  logic                         pop_i,
    output rom_resp_t                    head_dat_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   cnt_o
);

    localparam int unsigned PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CNT_W = $clog2(Depth + 1);

    rom_resp_t          mem_q [Depth];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               do_push;
    logic               do_pop;

    // Advance a pointer, wrapping at Depth so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(Depth - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full_o   = (cnt_q == CNT_W'(Depth));
    assign empty_o  = (cnt_q == '0);
    assign cnt_o    = cnt_q;

    // A pop of an empty FIFO is ignored; a push while full is only honoured
    // together with a pop (the head slot is then free to be reused).
    assign do_pop   = pop_i & ~empty_o;
    assign do_push  = push_i & (~full_o | do_pop);

    assign head_dat_o = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/rom_req_adapter.sv
// Boot-ROM front end: range-checks fetch requests, reads the ROM, buffers responses.
// Latency: grant in cycle N -> response at the FIFO head (rvalid_o) in N+2.
// Backpressure: grant withheld while buffered + in-flight responses fill the FIFO.
module rom_req_adapter
    import rom_adapter_pkg::*;
#(
    parameter logic [31:0] AddrOffset     = 32'h0001_0000,
    parameter int unsigned ROM_ADDR_WIDTH = 15,
    parameter bit          ByteAddressed  = 1'b0,
    parameter int unsigned RespDepth      = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        rom_csn_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_rdata_i
);

    localparam int unsigned CNT_W        = $clog2(RespDepth + 1);
    localparam logic [32:0] WINDOW_BYTES = rom_window_bytes(ROM_ADDR_WIDTH);

    // In-flight state: at most one response is between grant and FIFO push.
    logic               pend_q;
    logic               pend_err_q;
    logic [31:0]        rom_addr_q;

    // Request decode.
    logic [32:0]        offset;
    logic               bad_range;
    logic               bad;
    logic [31:0]        rom_addr_calc;
    logic               hs;
    logic               good_hs;
    logic               bad_hs;

    // Credit accounting.
    logic [CNT_W:0]     occupancy;
    logic               credit;

    // Response FIFO interface.
    logic               fifo_push;
    rom_resp_t          fifo_push_dat;
    logic               fifo_pop;
    rom_resp_t          fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_cnt;

    // Offset in 33 bits: an address below the window borrows into bit 32 and
    // therefore compares as out of range instead of wrapping into the window.
    assign offset    = {1'b0, addr_i} - {1'b0, AddrOffset};
    assign bad_range = offset[32] | (offset >= WINDOW_BYTES);
    assign bad       = we_i | (addr_i[1:0] != 2'b00) | bad_range;

    assign rom_addr_calc = ByteAddressed ? offset[31:0] : {2'b00, offset[31:2]};

    // Credit counts only registered state, so rready_i never reaches gnt_o.
    // A slot is reserved for every response already in flight.
    assign occupancy = (CNT_W + 1)'(fifo_cnt) + (CNT_W + 1)'(pend_q) + (CNT_W + 1)'(pend_err_q);
    assign credit    = (occupancy < (CNT_W + 1)'(RespDepth));
    assign gnt_o     = req_i & ~rst_i & credit;

    assign hs      = req_i & gnt_o;
    assign good_hs = hs & ~bad;
    assign bad_hs  = hs & bad;

    // ROM port: select only on a good handshake; the address holds otherwise.
    assign rom_csn_o  = ~good_hs;
    assign rom_addr_o = good_hs ? rom_addr_calc : rom_addr_q;

    // Track the in-flight response kind and remember the last ROM address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q     <= 1'b0;
            pend_err_q <= 1'b0;
            rom_addr_q <= 32'h0;
        end else begin
            pend_q     <= good_hs;
            pend_err_q <= bad_hs;
            if (good_hs) begin
                rom_addr_q <= rom_addr_calc;
            end
        end
    end

    // One handshake per cycle means at most one of pend_q/pend_err_q is set,
    // so pushing in grant order keeps good and error responses ordered.
    assign fifo_push     = pend_q | pend_err_q;
    assign fifo_push_dat = pend_err_q ? rom_err_resp() : rom_ok_resp(rom_rdata_i);
    assign fifo_pop      = rvalid_o & rready_i;

    rom_resp_fifo #(
        .Depth      (RespDepth)
    ) u_resp_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (fifo_push),
        .push_dat_i (fifo_push_dat),
        .pop_i      (fifo_pop),
        .head_dat_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .cnt_o      (fifo_cnt)
    );

    // Response port: the FIFO head is presented until popped; data reads as 0
    // whenever nothing is valid.
    assign rvalid_o = ~fifo_empty;
    assign rdata_o  = rvalid_o ? fifo_head.data : 32'h0;
    assign err_o    = rvalid_o & fifo_head.err;

    // The credit rule reserves a slot for every in-flight response.
    push_never_full_a : assert property (
        @(posedge clk_i) disable iff (rst_i) !(fifo_push && fifo_full)
    );

endmodule

// File: tb/tb_rom_req_adapter.sv
// Directed bench for rom_req_adapter with a queue-based response scoreboard.
// Latency: n/a.
// Backpressure: exercised by holding rready_i low.
module tb_rom_req_adapter;
    import rom_adapter_pkg::*;

    localparam logic [31:0] OFF = 32'h0001_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic        rvalid_o;
    logic        rready_i;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        rom_csn_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_rdata_i = 32'h0;

    // Second instance, byte-addressed ROM port.
    logic        req_b;
    logic        gnt_b;
    logic [31:0] addr_b;
    logic        rvalid_b;
    logic [31:0] rdata_b;
    logic        err_b;
    logic        csn_b;
    logic [31:0] rom_addr_b;
    logic [31:0] rom_rdata_b = 32'h0;

    int errors = 0;
    int checks = 0;
    rom_resp_t exp_q[$];

    always #5 clk_i = ~clk_i;

    rom_req_adapter #(
        .AddrOffset(OFF), .ROM_ADDR_WIDTH(15), .ByteAddressed(1'b0), .RespDepth(3)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
        .we_i(we_i), .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o),
        .err_o(err_o), .rom_csn_o(rom_csn_o), .rom_addr_o(rom_addr_o), .rom_rdata_i(rom_rdata_i)
    );

    rom_req_adapter #(
        .AddrOffset(OFF), .ROM_ADDR_WIDTH(15), .ByteAddressed(1'b1), .RespDepth(3)
    ) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_b), .gnt_o(gnt_b), .addr_i(addr_b),
        .we_i(1'b0), .rvalid_o(rvalid_b), .rready_i(1'b1), .rdata_o(rdata_b),
        .err_o(err_b), .rom_csn_o(csn_b), .rom_addr_o(rom_addr_b), .rom_rdata_i(rom_rdata_b)
    );

    // ROM contents: word i holds C0DE_0000 + i.
    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        return 32'hC0DE_0000 + idx;
    endfunction

    // 1-cycle-latency ROM macro model.
    always @(posedge clk_i) begin
        if (!rom_csn_o) rom_rdata_i <= rom_word(rom_addr_o);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response is compared with the scoreboard head.
    always @(negedge clk_i) begin
        rom_resp_t e;
        if (!rst_i) begin
            if (rvalid_o && rready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got err=%b data=%h, required no response", err_o, rdata_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_err", {31'h0, err_o}, {31'h0, e.err});
                    chk("resp_data", rdata_o, e.data);
                end
            end else if (!rvalid_o) begin
                chk("idle_rdata", rdata_o, 32'h0);
                chk("idle_err", {31'h0, err_o}, 32'h0);
            end
        end
    end

    // Issue one request; waits (bounded) for the grant, checks the ROM port in
    // the grant cycle and records the expected response.
    task automatic do_req(input logic [31:0] a, input logic w, input logic exp_err, output int waits);
        logic [31:0] idx;
        rom_resp_t   e;
        idx     = (a - OFF) >> 2;
        req_i   = 1'b1;
        addr_i  = a;
        we_i    = w;
        waits   = 0;
        @(negedge clk_i);
        while (!gnt_o && waits < 50) begin
            @(negedge clk_i);
            waits++;
        end
        if (!gnt_o) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got no gnt for addr %h, required gnt", a);
        end else begin
            chk("grant_csn", {31'h0, rom_csn_o}, {31'h0, exp_err});
            if (!exp_err) chk("grant_rom_addr", rom_addr_o, idx);
            e.err  = exp_err;
            e.data = exp_err ? 32'h0 : rom_word(idx);
            exp_q.push_back(e);
        end
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        we_i  = 1'b0;
    endtask

    // Wait (bounded) until every expected response has been consumed.
    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int w;
        int grants;
        logic [31:0] stall_addr;

        rst_i    = 1'b1;
        req_i    = 1'b0;
        addr_i   = 32'h0;
        we_i     = 1'b0;
        rready_i = 1'b1;
        req_b    = 1'b0;
        addr_b   = 32'h0;

        // Reset state, including a request held during reset.
        repeat (2) @(posedge clk_i);
        #1 req_i = 1'b1; addr_i = OFF;
        @(negedge clk_i);
        chk("rst_rvalid", {31'h0, rvalid_o}, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_err", {31'h0, err_o}, 32'h0);
        chk("rst_gnt", {31'h0, gnt_o}, 32'h0);
        chk("rst_csn", {31'h0, rom_csn_o}, 32'h1);
        chk("rst_rom_addr", rom_addr_o, 32'h0);
        @(posedge clk_i);
        #1 rst_i = 1'b0; req_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Single read of word 2: response exactly two cycles after the grant.
        do_req(OFF + 32'd8, 1'b0, 1'b0, w);
        @(negedge clk_i);
        chk("lat_n1_rvalid", {31'h0, rvalid_o}, 32'h0);
        @(negedge clk_i);
        chk("lat_n2_rvalid", {31'h0, rvalid_o}, 32'h1);
        chk("lat_n2_data", rdata_o, 32'hC0DE_0002);
        chk("lat_n2_err", {31'h0, err_o}, 32'h0);
        drain();

        // Eight back-to-back reads: a grant every cycle.
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 8; i++) begin
            do_req(OFF + 32'(4 * (3 * i + 1)), 1'b0, 1'b0, w);
            chk("b2b_gnt_wait", 32'(w), 32'h0);
        end
        drain();

        // Consumer stalled: exactly three grants, then none.
        @(posedge clk_i);
        #1 rready_i = 1'b0;
        req_i  = 1'b1;
        we_i   = 1'b0;
        grants = 0;
        for (int c = 0; c < 8; c++) begin
            stall_addr = OFF + 32'(4 * (100 + grants));
            addr_i = stall_addr;
            @(negedge clk_i);
            if (gnt_o) begin
                exp_q.push_back(rom_ok_resp(rom_word(32'(100 + grants))));
                grants++;
            end
            @(posedge clk_i);
            #1;
        end
        chk("stall_grants", 32'(grants), 32'd3);
        @(negedge clk_i);
        chk("stall_gnt_low", {31'h0, gnt_o}, 32'h0);
        chk("stall_rvalid_held", {31'h0, rvalid_o}, 32'h1);
        chk("stall_head_data", rdata_o, 32'hC0DE_0064);
        @(posedge clk_i);
        #1 req_i = 1'b0; rready_i = 1'b1;
        do_req(OFF + 32'd412, 1'b0, 1'b0, w);
        do_req(OFF + 32'd416, 1'b0, 1'b0, w);
        do_req(OFF + 32'd420, 1'b0, 1'b0, w);
        drain();

        // Error cases interleaved with good reads, including the last valid word.
        @(posedge clk_i);
        #1;
        do_req(OFF,                      1'b0, 1'b0, w);
        do_req(OFF - 32'd4,              1'b0, 1'b1, w);
        do_req(OFF + 32'd16,             1'b0, 1'b0, w);
        do_req(OFF + 32'h0002_0000,      1'b0, 1'b1, w);
        do_req(OFF + 32'd2,              1'b0, 1'b1, w);
        do_req(OFF + 32'd4,              1'b1, 1'b1, w);
        do_req(OFF + 32'h0001_FFFC,      1'b0, 1'b0, w);
        drain();

        // Reset one cycle after a grant: the in-flight read is dropped.
        @(posedge clk_i);
        #1;
        do_req(OFF + 32'd20, 1'b0, 1'b0, w);
        rst_i = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            chk("post_rst_rvalid", {31'h0, rvalid_o}, 32'h0);
        end
        @(posedge clk_i);
        #1;
        do_req(OFF + 32'd24, 1'b0, 1'b0, w);
        drain();

        // Byte-addressed instance: ROM address is the byte offset.
        @(posedge clk_i);
        #1 req_b = 1'b1; addr_b = OFF + 32'd12;
        @(negedge clk_i);
        chk("byte_gnt", {31'h0, gnt_b}, 32'h1);
        chk("byte_csn", {31'h0, csn_b}, 32'h0);
        chk("byte_rom_addr", rom_addr_b, 32'd12);
        @(posedge clk_i);
        #1 req_b = 1'b0;
        repeat (3) @(posedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop if the flow ever hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
